// File: rtl/fp32_minmax_reducer_if.sv
// Purpose: handshake bundle between a stream producer/consumer and fp32_minmax_reducer.
// Latency: none, wires only.
// Backpressure: in_ready stalls the producer and out_ready holds the result.
//
// Signals:
//   mode, in_valid, in_data, in_last  producer -> reducer
//   in_ready                          reducer  -> producer
//   out_valid, out_data, out_idx, out_count  reducer -> consumer
//   out_ready                         consumer -> reducer
interface fp32_minmax_reducer_if #(
    parameter int IDX_W = 8
);
    logic             mode;
    logic             in_valid;
    logic             in_ready;
    logic [31:0]      in_data;
    logic             in_last;
    logic             out_valid;
    logic             out_ready;
    logic [31:0]      out_data;
    logic [IDX_W-1:0] out_idx;
    logic [IDX_W-1:0] out_count;

    // master: the environment driving the stream and taking results
    modport master (
        output mode, in_valid, in_data, in_last, out_ready,
        input  in_ready, out_valid, out_data, out_idx, out_count
    );

    // slave: the reducer itself
    modport slave (
        input  mode, in_valid, in_data, in_last, out_ready,
        output in_ready, out_valid, out_data, out_idx, out_count
    );
endinterface

// File: rtl/fp32_minmax_reducer.sv
// Purpose: streaming FP32 min/max reduction of each window to one value plus its index.
// Latency: out_valid rises on the cycle after the closing transfer.
// Backpressure: in_ready drops while a result is held and returns on the cycle after it is consumed.
//
// Ports:
//   clk    rising-edge clock
//   reset  synchronous, active-high; discards partial and held state
//   bus    fp32_minmax_reducer_if.slave (input stream, result, handshakes)
// Optional build macro: FP_NAN_PROPAGATE_EN - any NaN in a window forces the result
//   to canonical qNaN 32'h7FC00000 with out_idx pointing at the first NaN.
module fp32_minmax_reducer #(
    parameter int WINDOW = 4,
    parameter int IDX_W  = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    fp32_minmax_reducer_if.slave bus
);
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ACCUM = 2'd1;
    localparam logic [1:0] HOLD  = 2'd2;

    // When WINDOW == 2**IDX_W this truncates to 0, which still matches the
    // wrapped increment on the final element.
    localparam logic [IDX_W-1:0] WIN_L = IDX_W'(WINDOW);

    logic [1:0]       state_q, state_d;
    logic             rdy_q;
    logic             mode_q;
    logic [31:0]      best_q;
    logic [IDX_W-1:0] best_idx_q;
    logic [IDX_W-1:0] cnt_q;

    logic             first, xfer, close, take, better, both_zero;
    logic [IDX_W-1:0] base_cnt, cnt_nxt;
    logic [31:0]      key_new, key_best, val;

    // Monotonic integer key: negatives are bit-inverted, positives get the
    // sign bit set, so unsigned compare follows the float ordering.
    function automatic logic [31:0] okey(input logic [31:0] b);
        return b[31] ? ~b : (b ^ 32'h8000_0000);
    endfunction

`ifdef FP_NAN_PROPAGATE_EN
    logic nan_q, nan_d, nan_in;
`endif

    always_comb begin
        first     = (state_q == IDLE);
        base_cnt  = first ? '0 : cnt_q;
        cnt_nxt   = base_cnt + IDX_W'(1);
        xfer      = bus.in_valid && rdy_q;
        close     = xfer && (bus.in_last || (cnt_nxt == WIN_L));
        key_new   = okey(bus.in_data);
        key_best  = okey(best_q);
        // +0 and -0 have different keys but must tie
        both_zero = (bus.in_data[30:0] == 31'd0) && (best_q[30:0] == 31'd0);
        better    = !both_zero && (mode_q ? (key_new > key_best) : (key_new < key_best));
        take      = first || better;
        val       = bus.in_data;
`ifdef FP_NAN_PROPAGATE_EN
        nan_in = (bus.in_data[30:23] == 8'hFF) && (bus.in_data[22:0] != 23'd0);
        nan_d  = first ? nan_in : (nan_q || nan_in);
        // nan_q is stale from the previous window on the first element
        if (!first && nan_q) begin
            take = 1'b0;
        end else if (nan_in) begin
            take = 1'b1;
            val  = 32'h7FC0_0000;
        end
`endif
        state_d = state_q;
        case (state_q)
            IDLE, ACCUM: if (xfer) state_d = close ? HOLD : ACCUM;
            HOLD:        if (bus.out_ready) state_d = IDLE;
            default:     state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            rdy_q      <= 1'b0;
            mode_q     <= 1'b0;
            best_q     <= 32'd0;
            best_idx_q <= '0;
            cnt_q      <= '0;
`ifdef FP_NAN_PROPAGATE_EN
            nan_q      <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            rdy_q   <= (state_d != HOLD);
            if (xfer) begin
                cnt_q <= cnt_nxt;
                if (first) mode_q <= bus.mode;
                if (take) begin
                    best_q     <= val;
                    best_idx_q <= base_cnt;
                end
`ifdef FP_NAN_PROPAGATE_EN
                nan_q <= nan_d;
`endif
            end
        end
    end

    assign bus.in_ready  = rdy_q;
    assign bus.out_valid = (state_q == HOLD);
    assign bus.out_data  = best_q;
    assign bus.out_idx   = best_idx_q;
    assign bus.out_count = cnt_q;
endmodule

// File: tb/tb_fp32_minmax_reducer.sv
// Purpose: self-checking bench for fp32_minmax_reducer (directed table, corner sequences, random vs model).
// Latency: expects out_valid on the cycle after each closing transfer.
// Backpressure: stalls results for random cycles and checks they hold steady.
module tb_fp32_minmax_reducer;
    localparam int WINDOW = 4;
    localparam int IDX_W  = 8;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    fp32_minmax_reducer_if #(.IDX_W(IDX_W)) bus ();

    fp32_minmax_reducer #(.WINDOW(WINDOW), .IDX_W(IDX_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_chk  = 0;
    int n_fail = 0;

    typedef struct {
        logic        m;
        int          n;
        logic [31:0] d [4];
        logic        lastf;
        logic [31:0] ed;
        int          ei;
        int          ec;
    } vec_t;

    vec_t vt [8];

    logic [31:0] win [WINDOW];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Ordering key from the float rule: negative values count down from the
    // top, positives count up from the middle.
    function automatic logic [31:0] ord(input logic [31:0] b);
        if (b[31]) return 32'hFFFF_FFFF - b;
        else       return b + 32'h8000_0000;
    endfunction

    function automatic bit is_zero(input logic [31:0] b);
        return (b == 32'h0000_0000) || (b == 32'h8000_0000);
    endfunction

    function automatic bit is_nan(input logic [31:0] b);
        return (b[30:23] == 8'hFF) && (b[22:0] != 0);
    endfunction

    // Reference: scan the window, keep the earliest extreme.
    task automatic model(input logic m, input int n, output logic [31:0] ed, output int ei);
        ed = win[0];
        ei = 0;
        for (int i = 1; i < n; i++) begin
            if (!(is_zero(win[i]) && is_zero(ed))) begin
                if (m ? (ord(win[i]) > ord(ed)) : (ord(win[i]) < ord(ed))) begin
                    ed = win[i];
                    ei = i;
                end
            end
        end
`ifdef FP_NAN_PROPAGATE_EN
        for (int i = n - 1; i >= 0; i--) begin
            if (is_nan(win[i])) begin
                ed = 32'h7FC0_0000;
                ei = i;
            end
        end
`endif
    endtask

    task automatic put(input logic [31:0] d, input logic l, input logic m);
        int t = 0;
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        bus.in_last  = l;
        bus.mode     = m;
        while (!bus.in_ready && t < 50) begin
            @(posedge clk); #1;
            t++;
        end
        if (t >= 50) chk("put_timeout", 32'd1, 32'd0);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
    endtask

    task automatic get(input string nm, input logic [31:0] ed, input int ei, input int ec, input int stall);
        chk({nm, "_latency"}, {31'd0, bus.out_valid}, 32'd1);
        chk({nm, "_data"},    bus.out_data, ed);
        chk({nm, "_idx"},     32'(bus.out_idx), 32'(ei));
        chk({nm, "_count"},   32'(bus.out_count), 32'(ec));
        chk({nm, "_inrdy0"},  {31'd0, bus.in_ready}, 32'd0);
        for (int s = 0; s < stall; s++) begin
            @(posedge clk); #1;
        end
        if (stall > 0) begin
            chk({nm, "_hold_vld"},  {31'd0, bus.out_valid}, 32'd1);
            chk({nm, "_hold_data"}, bus.out_data, ed);
        end
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        chk({nm, "_released"}, {31'd0, bus.out_valid}, 32'd0);
        chk({nm, "_inrdy1"},   {31'd0, bus.in_ready}, 32'd1);
    endtask

    initial begin
        logic [31:0] ed;
        int ei, n;
        logic m, lastf;

        // {mode, n, data, last on final, exp data, exp idx, exp count}
        vt[0] = '{1'b0, 4, '{32'h40600000, 32'h42200000, 32'hC0200000, 32'h40200000}, 1'b1, 32'hC0200000, 2, 4};
        vt[1] = '{1'b1, 2, '{32'h40600000, 32'hC2200000, 32'h0, 32'h0}, 1'b1, 32'h40600000, 0, 2};
        vt[2] = '{1'b0, 4, '{32'h00000000, 32'h80000000, 32'hC0600000, 32'hC0600000}, 1'b1, 32'hC0600000, 2, 4};
        vt[3] = '{1'b0, 2, '{32'h00000000, 32'h80000000, 32'h0, 32'h0}, 1'b1, 32'h00000000, 0, 2};
`ifdef FP_NAN_PROPAGATE_EN
        vt[4] = '{1'b0, 3, '{32'h3F800000, 32'h7FC00001, 32'hBF800000, 32'h0}, 1'b1, 32'h7FC00000, 1, 3};
`else
        vt[4] = '{1'b0, 3, '{32'h3F800000, 32'h7FC00001, 32'hBF800000, 32'h0}, 1'b1, 32'hBF800000, 2, 3};
`endif
        // closes on the WINDOW limit without in_last
        vt[5] = '{1'b1, 4, '{32'h3F800000, 32'h7F800000, 32'hFF800000, 32'h0}, 1'b0, 32'h7F800000, 1, 4};
        vt[6] = '{1'b1, 1, '{32'h80000000, 32'h0, 32'h0, 32'h0}, 1'b1, 32'h80000000, 0, 1};
        vt[7] = '{1'b1, 2, '{32'h80000000, 32'h00000000, 32'h0, 32'h0}, 1'b0, 32'h80000000, 0, 2};

        bus.mode = 1'b0; bus.in_valid = 1'b0; bus.in_data = 32'd0;
        bus.in_last = 1'b0; bus.out_ready = 1'b0;
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("rst_out_data",  bus.out_data, 32'd0);
        chk("rst_out_idx",   32'(bus.out_idx), 32'd0);
        chk("rst_out_count", 32'(bus.out_count), 32'd0);
        chk("rst_in_ready",  {31'd0, bus.in_ready}, 32'd0);
        reset = 1'b0;
        @(posedge clk); #1;
        chk("post_rst_in_ready", {31'd0, bus.in_ready}, 32'd1);

        // directed table; vt[7] needs in_last on element 2 to close, so set it
        for (int v = 0; v < 8; v++) begin
            for (int i = 0; i < vt[v].n; i++)
                put(vt[v].d[i], (i == vt[v].n - 1) && (vt[v].lastf || v == 7), vt[v].m);
            get($sformatf("vec%0d", v), vt[v].ed, vt[v].ei, vt[v].ec, v % 3);
        end

        // backpressure: 5 stalled cycles with junk driven at the input
        put(32'h3F800000, 1'b0, 1'b1);
        put(32'h40000000, 1'b1, 1'b0);
        bus.in_valid = 1'b1; bus.in_data = 32'h7F7FFFFF; bus.mode = 1'b1;
        for (int s = 0; s < 5; s++) begin
            @(posedge clk); #1;
            chk("bp_vld",  {31'd0, bus.out_valid}, 32'd1);
            chk("bp_rdy",  {31'd0, bus.in_ready}, 32'd0);
            chk("bp_data", bus.out_data, 32'h40000000);
        end
        bus.in_valid = 1'b0;
        get("bp", 32'h40000000, 1, 2, 0);
        put(32'hC0000000, 1'b1, 1'b0);
        get("bp_next", 32'hC0000000, 0, 1, 0);

        // reset mid-window discards the partial window
        put(32'h3F800000, 1'b0, 1'b0);
        put(32'hBF800000, 1'b0, 1'b0);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        chk("mid_rst_rdy",   {31'd0, bus.in_ready}, 32'd0);
        chk("mid_rst_count", 32'(bus.out_count), 32'd0);
        for (int s = 0; s < 3; s++) begin
            @(posedge clk); #1;
            chk("mid_rst_novld", {31'd0, bus.out_valid}, 32'd0);
        end
        put(32'h40200000, 1'b0, 1'b0);
        put(32'h40600000, 1'b0, 1'b1);
        put(32'h42200000, 1'b0, 1'b1);
        put(32'hC2200000, 1'b1, 1'b1);
        get("after_rst", 32'hC2200000, 3, 4, 1);

        // random windows against the model
        for (int w = 0; w < 60; w++) begin
            n = $urandom_range(1, WINDOW);
            m = 1'($urandom_range(0, 1));
            lastf = (n < WINDOW) ? 1'b1 : 1'($urandom_range(0, 1));
            for (int i = 0; i < n; i++) begin
                case ($urandom_range(0, 9))
                    0: win[i] = 32'h00000000;
                    1: win[i] = 32'h80000000;
                    2: win[i] = (i > 0) ? win[i-1] : 32'h3F800000;
                    3: win[i] = {1'($urandom_range(0, 1)), 8'hFF, 23'($urandom_range(1, 32'h7FFFFF))};
                    4: win[i] = {1'($urandom_range(0, 1)), 8'hFF, 23'd0};
                    default: win[i] = $urandom;
                endcase
            end
            model(m, n, ed, ei);
            for (int i = 0; i < n; i++) begin
                // mode is only honoured on the first element
                put(win[i], lastf && (i == n - 1), (i == 0) ? m : 1'($urandom_range(0, 1)));
                if (i < n - 1) begin
                    for (int g = $urandom_range(0, 2); g > 0; g--) begin
                        @(posedge clk); #1;
                    end
                end
            end
            get($sformatf("rnd%0d", w), ed, ei, n, $urandom_range(0, 3));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
